// File: rtl/dds_fcw_dec.sv
// DDS frequency-control-word decoder.
// Recovers the FCW by averaging phase differences.
module dds_fcw_dec #(
  parameter int WIDE_N   = 12,
  parameter int AVG_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [WIDE_N-1:0] phase_i,
  output logic [WIDE_N-1:0] fcw_o,
  output logic              fcw_vld_o,
  output logic              lock_o
);

  localparam int AW = WIDE_N + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    ACC
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [WIDE_N-1:0] phase_prev;
  logic [WIDE_N-1:0] d;
  logic [WIDE_N-1:0] fcw_new;
  logic [AW-1:0]     acc;
  logic [AW-1:0]     sum;
  logic [CW-1:0]     cnt;
  logic              have_est;
  logic              take;
  logic              win_done;

  // Next state, modular difference and window-complete detection
  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    win_done = 1'b0;
    d        = phase_i - phase_prev;
    sum      = acc + AW'(d);
    fcw_new  = WIDE_N'(sum >> AVG_LOG2);
    unique case (state_q)
      IDLE: begin
        if (en_i) state_d = PRIME;
      end
      PRIME, ACC: begin
        if (en_i) begin
          take     = 1'b1;
          state_d  = ACC;
          win_done = (cnt == CNT_LAST);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Reference phase, accumulator, estimate and lock tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_prev <= '0;
      acc        <= '0;
      cnt        <= '0;
      fcw_o      <= '0;
      fcw_vld_o  <= 1'b0;
      lock_o     <= 1'b0;
      have_est   <= 1'b0;
    end else begin
      fcw_vld_o <= 1'b0;
      if (en_i && state_q == IDLE) phase_prev <= phase_i;
      if (take) begin
        phase_prev <= phase_i;
        if (win_done) begin
          acc       <= '0;
          cnt       <= '0;
          fcw_o     <= fcw_new;
          fcw_vld_o <= 1'b1;
          lock_o    <= have_est && (fcw_new == fcw_o);
          have_est  <= 1'b1;
        end else begin
          acc <= sum;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dds_fcw_dec.sv
// Testbench for dds_fcw_dec.
// Table-driven vectors plus an averaging-off sequence.
module tb_dds_fcw_dec;

  typedef struct {
    logic        rst;
    logic        en;
    logic [11:0] ph;
    logic        vld;
    logic [11:0] fcw;
    logic        lock;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        en_i;
  logic [11:0] phase_i;
  logic [11:0] fcw_o;
  logic        fcw_vld_o;
  logic        lock_o;
  logic [11:0] fcw0;
  logic        vld0;
  logic        lock0;

  int checks;
  int errors;
  vec_t vecs[$];

  dds_fcw_dec #(.WIDE_N(12), .AVG_LOG2(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en_i     (en_i),
    .phase_i  (phase_i),
    .fcw_o    (fcw_o),
    .fcw_vld_o(fcw_vld_o),
    .lock_o   (lock_o)
  );

  dds_fcw_dec #(.WIDE_N(12), .AVG_LOG2(0)) dut0 (
    .clk      (clk),
    .rst      (rst),
    .en_i     (en_i),
    .phase_i  (phase_i),
    .fcw_o    (fcw0),
    .fcw_vld_o(vld0),
    .lock_o   (lock0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, int idx, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s [%0d] got %0d want %0d", nm, idx, act, exp);
    end
  endtask

  function automatic void push(logic r, logic e, logic [11:0] p,
                               logic v, logic [11:0] f, logic l);
    vec_t t;
    t.rst = r; t.en = e; t.ph = p;
    t.vld = v; t.fcw = f; t.lock = l;
    vecs.push_back(t);
  endfunction

  task automatic step(logic r, logic e, logic [11:0] p);
    rst = r; en_i = e; phase_i = p;
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(int idx, logic v, logic [11:0] f, logic l);
    chk("a0_vld", idx, int'(vld0), int'(v));
    chk("a0_fcw", idx, int'(fcw0), int'(f));
    chk("a0_lock", idx, int'(lock0), int'(l));
  endtask

  initial begin
    logic [11:0] ph;
    checks = 0;
    errors = 0;
    rst = 1'b1; en_i = 1'b0; phase_i = '0;

    // reset state, sample with rst=1 ignored
    push(1, 1, 12'd123, 0, 0, 0);
    push(1, 0, 12'd0, 0, 0, 0);

    // constant fcw 1000, crossing wrap
    for (int k = 1; k <= 49; k++)
      push(0, 1, 12'((k - 1) * 1000), (k == 17 || k == 33 || k == 49),
           (k >= 17) ? 12'd1000 : 12'd0, k >= 33);

    // alternating 1000/1001 diffs, sum 16008 truncates to 1000
    push(1, 0, 12'd0, 0, 0, 0);
    ph = 12'd3000;
    for (int k = 1; k <= 33; k++) begin
      push(0, 1, ph, (k == 17 || k == 33),
           (k >= 17) ? 12'd1000 : 12'd0, k >= 33);
      ph = ph + ((k % 2 == 1) ? 12'd1000 : 12'd1001);
    end

    // gapped input with junk phase in gaps
    push(1, 0, 12'd0, 0, 0, 0);
    for (int k = 1; k <= 33; k++) begin
      push(0, 1, 12'((k - 1) * 1000), (k == 17 || k == 33),
           (k >= 17) ? 12'd1000 : 12'd0, k >= 33);
      push(0, 0, 12'd7, 0,
           (k >= 17) ? 12'd1000 : 12'd0, k >= 33);
    end

    // fcw change 1000 -> 2000 at window boundary
    push(1, 0, 12'd0, 0, 0, 0);
    ph = 12'd0;
    for (int k = 1; k <= 49; k++) begin
      push(0, 1, ph, (k == 17 || k == 33 || k == 49),
           (k < 17) ? 12'd0 : (k < 33) ? 12'd1000 : 12'd2000,
           k >= 49);
      ph = ph + ((k < 17) ? 12'd1000 : 12'd2000);
    end

    // mid-window reset, then fcw 300, then constant phase
    push(1, 0, 12'd0, 0, 0, 0);
    for (int k = 1; k <= 10; k++)
      push(0, 1, 12'((k - 1) * 1000), 0, 0, 0);
    push(1, 1, 12'd555, 0, 0, 0);
    ph = 12'd50;
    for (int k = 1; k <= 49; k++) begin
      push(0, 1, ph, (k == 17 || k == 33 || k == 49),
           (k >= 17 && k < 33) ? 12'd300 : 12'd0, k >= 49);
      if (k < 17) ph = ph + 12'd300;
    end

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].ph);
      chk("vld", i, int'(fcw_vld_o), int'(vecs[i].vld));
      chk("fcw", i, int'(fcw_o), int'(vecs[i].fcw));
      chk("lock", i, int'(lock_o), int'(vecs[i].lock));
    end

    // averaging disabled: one estimate per difference
    step(1, 0, 12'd0);
    chk0(0, 0, 0, 0);
    step(0, 1, 12'd100);
    chk0(1, 0, 0, 0);
    step(0, 1, 12'd350);
    chk0(2, 1, 12'd250, 0);
    step(0, 1, 12'd600);
    chk0(3, 1, 12'd250, 1);
    step(0, 0, 12'd9);
    chk0(4, 0, 12'd250, 1);
    step(0, 1, 12'd500);
    chk0(5, 1, 12'd3996, 0);
    step(0, 1, 12'd400);
    chk0(6, 1, 12'd3996, 1);
    step(1, 1, 12'd5);
    chk0(7, 0, 0, 0);
    step(0, 1, 12'd5);
    chk0(8, 0, 0, 0);
    step(0, 1, 12'd5);
    chk0(9, 1, 0, 0);
    step(0, 1, 12'd5);
    chk0(10, 1, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
